uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Transmit-side sequencer for the UART, sitting between the 16x8 TX buffer FIFO and the serial line. It pops bytes from the FIFO read port when data is present and serialises each one as an asynchronous frame. A frame is one start bit, eight data bits LSB first, an optional parity bit and one or two stop bits, timed from a shared 16x-baud enable. It also reports busy/done status to the host register block.

## Interface
Parameters: none. Frame format is run-time configurable.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en_16_x_baud_i  in  1  one-clk-wide tick at 16x baud rate
- fifo_data_i  in  8  FIFO read data (head of queue), valid while fifo_data_present_i=1
- fifo_data_present_i  in  1  FIFO non-empty
- fifo_read_o  out  1  one-cycle pop strobe to FIFO read enable
- tx_pause_i  in  1  1 = do not start new frames; frame in flight completes
- parity_en_i  in  1  1 = insert parity bit
- parity_odd_i  in  1  0 = even, 1 = odd parity
- two_stop_i  in  1  1 = two stop bits
- tx_o  out  1  serial line, idle high
- busy_o  out  1  frame in progress
- tx_done_o  out  1  one-cycle pulse at end of each frame

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - tick_cnt[3:0]: counts en_16_x_baud_i pulses within a bit.
  - bit_cnt[2:0]: data bit index, reused as the stop bit index.
- Bit boundary: a bit ends when en_16_x_baud_i=1 and tick_cnt=15. tick_cnt then wraps to 0.
- IDLE:
  - tx_o=1.
  - fifo_read_o = (state==IDLE) & fifo_data_present_i & ~tx_pause_i. This is combinational from registered state and inputs.
  - In a pop cycle: latch fifo_data_i into shift_reg[7:0].
  - In the same pop cycle: latch parity_en_i, parity_odd_i and two_stop_i into frame config registers, then go to START. Config changes mid-frame have no effect.
  - Parity is computed from the latched byte: par = ^data ^ parity_odd.
- START: tx_o=0 for 16 ticks, then go to DATA with bit_cnt=0.
- DATA:
  - tx_o=shift_reg[0] for 16 ticks per bit.
  - At each bit boundary, shift right and increment bit_cnt.
  - After bit 7: go to PARITY if parity enabled, else to STOP.
- PARITY: tx_o=par for 16 ticks, then go to STOP.
- STOP:
  - tx_o=1 for 16 ticks with one stop bit, 32 ticks with two.
  - At the final boundary: pulse tx_done_o and return to IDLE.
- busy_o = (state != IDLE).
- Pause: tx_pause_i sampled only in IDLE. Asserting it mid-frame does not truncate the frame.
- FIFO empty: no pop, stay in IDLE, tx_o=1.
- Popping only when fifo_data_present_i=1 guarantees no underflow. At most one pop per frame.

## Timing
- Reset values:
  - state=IDLE, tx_o=1, busy_o=0, tx_done_o=0, fifo_read_o=0 (no data present).
  - tick_cnt=0, bit_cnt=0, shift_reg=0.
- Reset mid-frame: tx_o returns high asynchronously and the frame is abandoned. The popped byte is lost; the FIFO is not rewound.
- Pop to line: pop in cycle N; state=START, tx_o=0 and busy_o=1 from edge N+1.
- Start bit length: 16 ticks counted from the first tick at or after cycle N+1. The start bit may therefore exceed 16 tick periods by less than one tick period. All later bits are exactly 16 tick periods.
- Frame length in ticks: 16*(10 + parity_en + two_stop).
- tx_done_o is registered: high for the one cycle after the final stop boundary, coinciding with state=IDLE.
- Back-to-back frames: if data is present and not paused, the next pop occurs in that same IDLE cycle. The gap between frames is one clk of idle-high beyond the stop bit(s).
- tx_o is registered and glitch-free. fifo_read_o is never high two consecutive cycles.

## Test plan
- Reset, FIFO empty, ticks running -> tx_o=1, busy_o=0, fifo_read_o never asserted for 1000 cycles.
- Push 0x55; no parity, one stop -> single pop. tx_o = 0,1,0,1,0,1,0,1,0,1, each 16 ticks (160 ticks total); one tx_done_o pulse; busy_o low after.
- Push 0x07; parity even -> parity bit 1. Push 0x07; parity odd -> parity bit 0. Two stop bits -> line high for 32 ticks before tx_done_o; frame = 192 ticks.
- Push 0xA3, 0x3C back-to-back -> two pops separated by exactly one frame plus one clk. Data bits LSB first (0xA3 = 1,1,0,0,0,1,0,1). FIFO empty afterwards.
- Change parity_en_i and two_stop_i mid-frame -> current frame unaffected; next frame uses new settings. Assert tx_pause_i during DATA -> frame completes, no further pop until release.
- Assert rst_n=0 in the middle of DATA -> tx_o=1 immediately, busy_o=0. After release, the next queued byte transmits as a clean full frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the TX FIFO and serialises start/data/parity/stop frames.
// Latency: pop in cycle N, start bit on tx_o from edge N+1; tx_done_o one cycle after the final stop boundary.
// Backpressure: pops only in IDLE when FIFO is non-empty and tx_pause_i=0; at most one pop per frame.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   en_16_x_baud_i        one-clk tick at 16x baud
//   fifo_data_i           FIFO head byte, valid while fifo_data_present_i=1
//   fifo_data_present_i   FIFO non-empty
//   fifo_read_o           one-cycle pop strobe (combinational from state + inputs)
//   tx_pause_i            hold off new frames (sampled only in IDLE)
//   parity_en_i           insert parity bit
//   parity_odd_i          0 = even, 1 = odd parity
//   two_stop_i            two stop bits
//   tx_o                  registered serial line, idle high
//   busy_o                frame in progress
//   tx_done_o             one-cycle pulse after each completed frame
module uart_tx_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_16_x_baud_i,
  input  logic [7:0] fifo_data_i,
  input  logic       fifo_data_present_i,
  output logic       fifo_read_o,
  input  logic       tx_pause_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       two_stop_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, state_nxt;
  logic [3:0] tick_cnt, tick_cnt_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift_reg, shift_reg_nxt;
  logic       cfg_par_en, cfg_par_en_nxt;
  logic       cfg_two_stop, cfg_two_stop_nxt;
  logic       par_bit, par_bit_nxt;
  logic       tx_q, tx_nxt;
  logic       done_q, done_nxt;
  logic       pop;
  logic       bit_end;

  assign pop         = (state == IDLE) & fifo_data_present_i & ~tx_pause_i;
  assign bit_end     = en_16_x_baud_i & (tick_cnt == 4'd15);
  assign fifo_read_o = pop;
  assign busy_o      = (state != IDLE);
  assign tx_o        = tx_q;
  assign tx_done_o   = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= 4'd0;
      bit_cnt      <= 3'd0;
      shift_reg    <= 8'd0;
      cfg_par_en   <= 1'b0;
      cfg_two_stop <= 1'b0;
      par_bit      <= 1'b0;
      tx_q         <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      tick_cnt     <= tick_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift_reg    <= shift_reg_nxt;
      cfg_par_en   <= cfg_par_en_nxt;
      cfg_two_stop <= cfg_two_stop_nxt;
      par_bit      <= par_bit_nxt;
      tx_q         <= tx_nxt;
      done_q       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    tick_cnt_nxt     = tick_cnt;
    bit_cnt_nxt      = bit_cnt;
    shift_reg_nxt    = shift_reg;
    cfg_par_en_nxt   = cfg_par_en;
    cfg_two_stop_nxt = cfg_two_stop;
    par_bit_nxt      = par_bit;
    done_nxt         = 1'b0;
    tx_nxt           = 1'b1;

    // Ticks are only counted inside a frame; the 4-bit counter wraps at each bit boundary.
    if ((state != IDLE) && en_16_x_baud_i) begin
      tick_cnt_nxt = tick_cnt + 4'd1;
    end

    case (state)
      IDLE: begin
        // Holding the counter at zero makes the start bit begin with the first tick after the pop.
        tick_cnt_nxt = 4'd0;
        bit_cnt_nxt  = 3'd0;
        if (pop) begin
          shift_reg_nxt    = fifo_data_i;
          cfg_par_en_nxt   = parity_en_i;
          cfg_two_stop_nxt = two_stop_i;
          par_bit_nxt      = (^fifo_data_i) ^ parity_odd_i;
          state_nxt        = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_reg_nxt = {1'b0, shift_reg[7:1]};
          // After bit 7 the counter wraps to 0, ready to index stop bits.
          bit_cnt_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nxt = cfg_par_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt   = STOP;
          bit_cnt_nxt = 3'd0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (cfg_two_stop && (bit_cnt == 3'd0)) begin
            bit_cnt_nxt = 3'd1;
          end else begin
            state_nxt   = IDLE;
            bit_cnt_nxt = 3'd0;
            done_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Line level is derived from the next state so tx_o changes on the same edge as the state.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_reg_nxt[0];
      PARITY:  tx_nxt = par_bit_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: FIFO model, random baud ticks, frame-level line model.
// Latency: checks every cycle on the falling edge.
// Backpressure: FIFO model pops only on an observed fifo_read_o.
module tb_uart_tx_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en_16_x_baud_i;
  logic [7:0] fifo_data_i;
  logic       fifo_data_present_i;
  logic       fifo_read_o;
  logic       tx_pause_i;
  logic       parity_en_i;
  logic       parity_odd_i;
  logic       two_stop_i;
  logic       tx_o;
  logic       busy_o;
  logic       tx_done_o;

  uart_tx_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en_16_x_baud_i      (en_16_x_baud_i),
    .fifo_data_i         (fifo_data_i),
    .fifo_data_present_i (fifo_data_present_i),
    .fifo_read_o         (fifo_read_o),
    .tx_pause_i          (tx_pause_i),
    .parity_en_i         (parity_en_i),
    .parity_odd_i        (parity_odd_i),
    .two_stop_i          (two_stop_i),
    .tx_o                (tx_o),
    .busy_o              (busy_o),
    .tx_done_o           (tx_done_o)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_pushes = 0;
  int n_pops   = 0;

  logic [7:0] fifo_q[$];

  // Frame model: expected line levels, one entry per bit, each lasting 16 ticks.
  logic exp_bits [0:11];
  int   nbits    = 0;
  int   tick_k   = 0;
  bit   in_frame = 0;
  bit   done_exp = 0;
  bit   pop_pend = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Input driver: FIFO head and random baud ticks, updated just after each rising edge.
  initial begin : drive
    en_16_x_baud_i      = 1'b0;
    fifo_data_i         = 8'h00;
    fifo_data_present_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend && fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifo_data_present_i = (fifo_q.size() != 0);
      fifo_data_i         = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      en_16_x_baud_i      = ($urandom_range(0, 2) == 0);
    end
  end

  // Reference model and per-cycle checks on the falling edge.
  initial begin : monitor
    logic [7:0] b;
    bit         done_nxt;
    forever begin
      @(negedge clk);
      pop_pend = 1'b0;
      if (!rst_n) begin
        in_frame = 1'b0;
        done_exp = 1'b0;
      end else begin
        done_nxt = 1'b0;
        chk("tx_done", tx_done_o, done_exp);
        chk("busy", busy_o, in_frame);
        if (in_frame) begin
          chk("tx_bit", tx_o, exp_bits[tick_k / 16]);
          chk("read_in_frame", fifo_read_o, 0);
          if (en_16_x_baud_i) begin
            tick_k++;
            if (tick_k == 16 * nbits) begin
              in_frame = 1'b0;
              done_nxt = 1'b1;
            end
          end
        end else begin
          chk("tx_idle", tx_o, 1);
          chk("read_idle", fifo_read_o, fifo_data_present_i & ~tx_pause_i);
          if (fifo_read_o) begin
            b           = fifo_data_i;
            exp_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[1 + i] = b[i];
            nbits = 9;
            if (parity_en_i) begin
              exp_bits[nbits] = (^b) ^ parity_odd_i;
              nbits++;
            end
            exp_bits[nbits] = 1'b1;
            nbits++;
            if (two_stop_i) begin
              exp_bits[nbits] = 1'b1;
              nbits++;
            end
            tick_k   = 0;
            in_frame = 1'b1;
            pop_pend = 1'b1;
            n_pops++;
          end
        end
        done_exp = done_nxt;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    n_pushes++;
  endtask

  task automatic set_cfg(input logic pe, input logic po, input logic ts);
    parity_en_i  = pe;
    parity_odd_i = po;
    two_stop_i   = ts;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(fifo_q.size() == 0 && !in_frame && !pop_pend) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("idle_timeout", (n >= budget), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_ticks(input int k, input int budget);
    int n = 0;
    while (!(in_frame && tick_k >= k) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("tick_timeout", (n >= budget), 0);
  endtask

  initial begin : main
    rst_n      = 1'b1;
    tx_pause_i = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #20;
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", tx_done_o, 0);
    chk("rst_read", fifo_read_o, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Empty FIFO with ticks running: line idle, no pops.
    repeat (1000) @(posedge clk);
    #2;
    chk("empty_no_pops", n_pops, 0);

    // 0x55, no parity, one stop.
    push(8'h55);
    wait_idle(5000);
    chk("pops_55", n_pops, 1);

    // 0x07 even parity, then odd parity with two stops.
    set_cfg(1'b1, 1'b0, 1'b0);
    push(8'h07);
    wait_idle(5000);
    set_cfg(1'b1, 1'b1, 1'b1);
    push(8'h07);
    wait_idle(5000);

    // Back-to-back frames.
    set_cfg(1'b0, 1'b0, 1'b0);
    push(8'hA3);
    push(8'h3C);
    wait_idle(10000);
    chk("b2b_empty", fifo_data_present_i, 0);
    chk("pops_b2b", n_pops, 5);

    // Config change mid-frame affects only the next frame.
    set_cfg(1'b1, 1'b0, 1'b0);
    push(8'hC5);
    push(8'h19);
    wait_ticks(40, 3000);
    set_cfg(1'b0, 1'b1, 1'b1);
    wait_idle(10000);

    // Pause during DATA: frame completes, next byte held.
    push(8'h6E);
    push(8'h81);
    wait_ticks(40, 3000);
    tx_pause_i = 1'b1;
    begin
      int n = 0;
      while (in_frame && n < 3000) begin
        @(posedge clk);
        #2;
        n++;
      end
      chk("pause_frame_timeout", (n >= 3000), 0);
    end
    repeat (200) @(posedge clk);
    #2;
    chk("pause_held", fifo_data_present_i, 1);
    chk("pause_fifo_level", fifo_q.size(), 1);
    tx_pause_i = 1'b0;
    wait_idle(5000);

    // Reset in the middle of DATA: line high at once, next byte sent cleanly.
    push(8'hB2);
    push(8'h4D);
    wait_ticks(40, 3000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx_o, 1);
    chk("midrst_busy", busy_o, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_idle(5000);
    chk("midrst_pops", n_pops, n_pushes);

    // Randomised traffic with config churn and pause toggling.
    for (int it = 0; it < 12; it++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) push(8'($urandom));
      set_cfg(1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(50, 400)) begin
        @(posedge clk);
        #2;
        if ($urandom_range(0, 63) == 0) tx_pause_i = ~tx_pause_i;
        if ($urandom_range(0, 99) == 0) set_cfg(1'($urandom), 1'($urandom), 1'($urandom));
      end
      tx_pause_i = 1'b0;
    end
    wait_idle(40000);
    chk("final_empty", fifo_data_present_i, 0);
    chk("final_pops", n_pops, n_pushes);
    chk("final_busy", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
